// File: rtl/irq_pkg.sv
// Shared definitions for the 9-channel interrupt request controller.
//   NUM_CH   : number of interrupt channels (channel 0 = highest priority)
//   ID_W     : channel ID width (2**ID_W > NUM_CH so NO_ID never aliases a channel)
//   NO_ID    : ID presented when no channel is presented or in service
//   state_t  : request/service FSM states
//   irq_out_t: registered CPU-facing output bundle
package irq_pkg;

    localparam int unsigned NUM_CH = 9;
    localparam int unsigned ID_W   = 4;

    localparam logic [ID_W-1:0] NO_ID = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            busy;
        logic            spurious;
    } irq_out_t;

    localparam irq_out_t OUT_IDLE = '{valid: 1'b0, id: NO_ID, busy: 1'b0, spurious: 1'b0};

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
//   cand : candidate request vector (bit 0 = highest priority)
//   any  : at least one candidate is set
//   id   : index of the lowest set candidate, NO_ID when none
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_CH-1:0] cand,
    output logic              any,
    output logic [ID_W-1:0]   id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any = |cand;
        id  = NO_ID;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_req_ctrl.sv
// Interrupt request controller: synchronises NUM_CH asynchronous request lines,
// keeps a per-channel pending vector (edge or level triggered), masks it, picks
// the lowest-index candidate and presents it to the CPU with a valid/ack
// handshake, then holds it in service until end-of-interrupt.
//   clk, rst_n : clock, asynchronous active-low reset
//   irq_in     : raw asynchronous request lines
//   edge_mode  : per channel, 1 = rising-edge triggered, 0 = level
//   mask       : per channel, 1 = excluded from selection (pending kept)
//   irq_valid  : a request is being presented
//   irq_id     : presented / in-service channel, NO_ID otherwise
//   irq_ack    : CPU accepts the presented request (PRESENT only)
//   eoi        : end-of-interrupt (SERVICE only)
//   busy       : a request is in service
//   spurious   : one-cycle pulse when a presented request is withdrawn
//   pending_o  : current pending vector
module irq_req_ctrl
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic [NUM_CH-1:0] edge_mode,
    input  logic [NUM_CH-1:0] mask,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack,
    input  logic              eoi,
    output logic              busy,
    output logic              spurious,
    output logic [NUM_CH-1:0] pending_o
);

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] sync_prev_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_n;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] cur_oh;
    logic              cur_is_cand;

    logic              enc_any;
    logic [ID_W-1:0]   enc_id;

    state_t            state_q;
    state_t            state_n;
    logic [ID_W-1:0]   cur_id_q;
    logic [ID_W-1:0]   cur_id_n;
    irq_out_t          out_q;
    irq_out_t          out_n;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync_prev_q <= '0;
        end else begin
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    // Pending update: edge channels latch rises and clear on ack (a rise in the
    // ack cycle wins); level channels simply track the synchronised line.
    always_comb begin
        cur_oh = NUM_CH'(1) << cur_id_q;
        rise   = sync2_q & ~sync_prev_q;
        clr    = '0;
        if ((state_q == PRESENT) && irq_ack) begin
            clr = cur_oh;
        end
        pend_n = (edge_mode & (rise | (pend_q & ~clr))) | (~edge_mode & sync2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_n;
        end
    end

    assign cand        = pend_q & ~mask;
    assign cur_is_cand = |(cand & cur_oh);

    irq_prio_enc u_prio_enc (
        .cand (cand),
        .any  (enc_any),
        .id   (enc_id)
    );

    // State, latched channel and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_id_q <= NO_ID;
            out_q    <= OUT_IDLE;
        end else begin
            state_q  <= state_n;
            cur_id_q <= cur_id_n;
            out_q    <= out_n;
        end
    end

    // Next state and next registered outputs. The presented ID is frozen in
    // cur_id, so later higher-priority arrivals wait for the next IDLE pass.
    always_comb begin
        state_n  = state_q;
        cur_id_n = cur_id_q;
        out_n    = OUT_IDLE;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_n     = PRESENT;
                    cur_id_n    = enc_id;
                    out_n.valid = 1'b1;
                    out_n.id    = enc_id;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    state_n    = SERVICE;
                    out_n.busy = 1'b1;
                    out_n.id   = cur_id_q;
                end else if (!cur_is_cand) begin
                    state_n        = IDLE;
                    out_n.spurious = 1'b1;
                end else begin
                    out_n.valid = 1'b1;
                    out_n.id    = cur_id_q;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_n = IDLE;
                end else begin
                    out_n.busy = 1'b1;
                    out_n.id   = cur_id_q;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign irq_valid = out_q.valid;
    assign irq_id    = out_q.id;
    assign busy      = out_q.busy;
    assign spurious  = out_q.spurious;
    assign pending_o = pend_q;

endmodule

// File: tb/tb_irq_req_ctrl.sv
// Self-checking bench for irq_req_ctrl: per-cycle stimulus/expectation table,
// expectations queued when stimulus is driven and compared after the edge.
module tb_irq_req_ctrl;

    logic       clk;
    logic       rst_n;
    logic [8:0] irq_in;
    logic [8:0] edge_mode;
    logic [8:0] mask;
    logic       irq_ack;
    logic       eoi;
    logic       irq_valid;
    logic [3:0] irq_id;
    logic       busy;
    logic       spurious;
    logic [8:0] pending_o;

    int total;
    int bad;

    typedef struct {
        string      tag;
        logic [8:0] irq;
        logic [8:0] msk;
        logic       ack;
        logic       eoi;
        logic       valid;
        logic [3:0] id;
        logic       busy;
        logic       spur;
        logic [8:0] pend;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    irq_req_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .edge_mode (edge_mode),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .eoi       (eoi),
        .busy      (busy),
        .spurious  (spurious),
        .pending_o (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(string tag, logic [8:0] irq, logic [8:0] msk,
                               logic ack, logic e, logic valid, logic [3:0] id,
                               logic bsy, logic spur, logic [8:0] pend);
        vec_t r;
        r.tag = tag; r.irq = irq; r.msk = msk; r.ack = ack; r.eoi = e;
        r.valid = valid; r.id = id; r.busy = bsy; r.spur = spur; r.pend = pend;
        return r;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, step, act, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t t, input int idx);
        vec_t e;
        irq_in  = t.irq;
        mask    = t.msk;
        irq_ack = t.ack;
        eoi     = t.eoi;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", idx, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".valid"},    idx, 32'(irq_valid), 32'(e.valid));
            chk({e.tag, ".id"},       idx, 32'(irq_id),    32'(e.id));
            chk({e.tag, ".busy"},     idx, 32'(busy),      32'(e.busy));
            chk({e.tag, ".spurious"}, idx, 32'(spurious),  32'(e.spur));
            chk({e.tag, ".pending"},  idx, 32'(pending_o), 32'(e.pend));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n     = 1'b1;
        irq_in    = '0;
        edge_mode = 9'h1EF;   // channel 4 level, all others edge
        mask      = '0;
        irq_ack   = 1'b0;
        eoi       = 1'b0;

        // tag, irq, mask, ack, eoi | valid, id, busy, spurious, pending
        // Edge request on channel 5, stray ack in IDLE ignored.
        tbl.push_back(v("edge5", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("edge5", 9'h020, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("edge5", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("edge5", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h020));
        tbl.push_back(v("edge5", 9'h000, 9'h0, 0, 0, 1, 4'h5, 0, 0, 9'h020));
        tbl.push_back(v("edge5", 9'h000, 9'h0, 1, 0, 0, 4'h5, 1, 0, 9'h000));
        tbl.push_back(v("edge5", 9'h000, 9'h0, 0, 0, 0, 4'h5, 1, 0, 9'h000));
        tbl.push_back(v("edge5", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("idle_ack", 9'h000, 9'h0, 1, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("idle_ack", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        // Priority 3 over 7, channel 1 arrives in PRESENT, eoi in PRESENT ignored.
        tbl.push_back(v("prio", 9'h088, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h088));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 1, 4'h3, 0, 0, 9'h088));
        tbl.push_back(v("prio", 9'h002, 9'h0, 0, 1, 1, 4'h3, 0, 0, 9'h088));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 1, 4'h3, 0, 0, 9'h088));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 1, 4'h3, 0, 0, 9'h08A));
        tbl.push_back(v("prio", 9'h000, 9'h0, 1, 0, 0, 4'h3, 1, 0, 9'h082));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h082));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 1, 4'h1, 0, 0, 9'h082));
        tbl.push_back(v("prio", 9'h000, 9'h0, 1, 0, 0, 4'h1, 1, 0, 9'h080));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h080));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 0, 1, 4'h7, 0, 0, 9'h080));
        tbl.push_back(v("prio", 9'h000, 9'h0, 1, 0, 0, 4'h7, 1, 0, 9'h000));
        tbl.push_back(v("prio", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h000));
        // Masked channel 2 stays pending, presented the cycle the mask clears.
        tbl.push_back(v("mask", 9'h004, 9'h004, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("mask", 9'h000, 9'h004, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("mask", 9'h000, 9'h004, 0, 0, 0, 4'hF, 0, 0, 9'h004));
        tbl.push_back(v("mask", 9'h000, 9'h004, 0, 0, 0, 4'hF, 0, 0, 9'h004));
        tbl.push_back(v("mask", 9'h000, 9'h000, 0, 0, 1, 4'h2, 0, 0, 9'h004));
        tbl.push_back(v("mask", 9'h000, 9'h000, 1, 0, 0, 4'h2, 1, 0, 9'h000));
        tbl.push_back(v("mask", 9'h000, 9'h000, 0, 1, 0, 4'hF, 0, 0, 9'h000));
        // Level channel 4 withdrawn while presented: one spurious pulse, no busy.
        tbl.push_back(v("level4", 9'h010, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("level4", 9'h010, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("level4", 9'h010, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h010));
        tbl.push_back(v("level4", 9'h010, 9'h0, 0, 0, 1, 4'h4, 0, 0, 9'h010));
        tbl.push_back(v("level4", 9'h000, 9'h0, 0, 0, 1, 4'h4, 0, 0, 9'h010));
        tbl.push_back(v("level4", 9'h000, 9'h0, 0, 0, 1, 4'h4, 0, 0, 9'h010));
        tbl.push_back(v("level4", 9'h000, 9'h0, 0, 0, 1, 4'h4, 0, 0, 9'h000));
        tbl.push_back(v("level4", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 1, 9'h000));
        tbl.push_back(v("level4", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        // New edge on channel 6 lands in its own ack cycle: set beats clear.
        tbl.push_back(v("simul6", 9'h040, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h040, 9'h0, 0, 0, 1, 4'h6, 0, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 0, 1, 4'h6, 0, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 1, 0, 0, 4'h6, 1, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 0, 0, 4'h6, 1, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 0, 1, 4'h6, 0, 0, 9'h040));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 1, 0, 0, 4'h6, 1, 0, 9'h000));
        tbl.push_back(v("simul6", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h000));
        // Reach SERVICE on channel 0 with channel 8 still pending.
        tbl.push_back(v("pre_rst", 9'h101, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("pre_rst", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000));
        tbl.push_back(v("pre_rst", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h101));
        tbl.push_back(v("pre_rst", 9'h000, 9'h0, 0, 0, 1, 4'h0, 0, 0, 9'h101));
        tbl.push_back(v("pre_rst", 9'h000, 9'h0, 1, 0, 0, 4'h0, 1, 0, 9'h100));

        // Power-on reset values.
        #1 rst_n = 1'b0;
        #2;
        chk("reset.valid",    0, 32'(irq_valid), 32'd0);
        chk("reset.id",       0, 32'(irq_id),    32'hF);
        chk("reset.busy",     0, 32'(busy),      32'd0);
        chk("reset.spurious", 0, 32'(spurious),  32'd0);
        chk("reset.pending",  0, 32'(pending_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Asynchronous reset in SERVICE, with level channel 4 held high across it.
        #2;
        rst_n  = 1'b0;
        irq_in = 9'h010;
        #1;
        chk("midrst.busy",     100, 32'(busy),      32'd0);
        chk("midrst.valid",    100, 32'(irq_valid), 32'd0);
        chk("midrst.id",       100, 32'(irq_id),    32'hF);
        chk("midrst.pending",  100, 32'(pending_o), 32'd0);
        chk("midrst.spurious", 100, 32'(spurious),  32'd0);
        #1 rst_n = 1'b1;

        // Level source re-pends from scratch; edge channel 8 is not recovered.
        step(v("post_rst", 9'h010, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000), 101);
        step(v("post_rst", 9'h010, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000), 102);
        step(v("post_rst", 9'h010, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h010), 103);
        step(v("post_rst", 9'h010, 9'h0, 0, 0, 1, 4'h4, 0, 0, 9'h010), 104);
        // Level ack leaves pending alone; dropping the line in SERVICE is not spurious.
        step(v("post_rst", 9'h000, 9'h0, 1, 0, 0, 4'h4, 1, 0, 9'h010), 105);
        step(v("post_rst", 9'h000, 9'h0, 0, 0, 0, 4'h4, 1, 0, 9'h010), 106);
        step(v("post_rst", 9'h000, 9'h0, 0, 1, 0, 4'hF, 0, 0, 9'h000), 107);
        step(v("post_rst", 9'h000, 9'h0, 0, 0, 0, 4'hF, 0, 0, 9'h000), 108);

        chk("scoreboard_drained", 200, 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_req_ctrl.md
# irq_req_ctrl

Sequential interrupt-request controller that sits between nine asynchronous interrupt sources and the CPU. It is the requesting and servicing end of the team's 9-channel priority interrupt path. It synchronises and latches requests per channel, applies masking, and selects the highest-priority channel. It then presents that channel's ID with a valid/ack handshake and holds the channel in service until end-of-interrupt.

## Interface
- NUM_CH, 9: number of interrupt channels; channel 0 has highest priority.
- ID_W, 4: width of the channel ID; must satisfy 2^ID_W > NUM_CH.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_CH  raw asynchronous request lines.
- edge_mode  in  NUM_CH  per channel, quasi-static: 1 = rising-edge triggered, 0 = level.
- mask  in  NUM_CH  1 blocks that channel from selection; its pending state is kept.
- irq_valid  out  1  a request is being presented to the CPU.
- irq_id  out  ID_W  ID of the presented or in-service channel; NO_ID when idle.
- irq_ack  in  1  CPU accepts the presented request; sampled only in PRESENT.
- eoi  in  1  end-of-interrupt pulse; sampled only in SERVICE.
- busy  out  1  high in SERVICE.
- spurious  out  1  one-cycle pulse when a presented request is withdrawn.
- pending_o  out  NUM_CH  current pending vector.
- All outputs reset to 0, except irq_id, which resets to NO_ID (all ones).

## Operation
- **Synchroniser:** a 2-flop chain per channel, reset to 0.
- **Edge-mode pending:**
  - Set on a rising edge of the synchronised line.
  - Cleared when that channel is acked.
  - If set and clear occur in the same cycle, set wins.
- **Level-mode pending:** equals the synchronised level. Ack does not clear it; the source must deassert.
- **Candidates:** `pending & ~mask`. The lowest index wins.
- **FSM, IDLE:**
  - If any candidate exists, register the winner into cur_id and go to PRESENT.
  - Otherwise stay in IDLE.
- **FSM, PRESENT:**
  - irq_valid=1 and irq_id=cur_id. irq_id is held stable; a newly arriving higher-priority candidate does not replace it.
  - If irq_ack=1: clear the pending bit of cur_id (edge mode only) and go to SERVICE.
  - Else if cur_id is no longer a candidate (masked, or level dropped): pulse spurious, go to IDLE, irq_id=NO_ID.
  - If ack and withdrawal occur in the same cycle, ack wins.
- **FSM, SERVICE:**
  - busy=1 and irq_id=cur_id.
  - No nesting: new requests only accumulate as pending.
  - eoi=1 returns the FSM to IDLE.
- irq_ack outside PRESENT is ignored. eoi outside SERVICE is ignored.
- Changing edge_mode while a channel is pending is undefined; the bench must not do it.
- Reset mid-operation: everything returns asynchronously to reset values and any presented or in-service request is lost. Only requests that are still active afterwards re-enter pending (edge mode needs a new rising edge).

## Timing
- irq_in rises and is sampled at edge k:
  - synchronised at edge k+1;
  - pending at edge k+2;
  - PRESENT at edge k+3;
  - irq_valid visible after edge k+3.
- irq_ack sampled high at edge n: SERVICE and busy from edge n; irq_valid low from edge n.
- eoi sampled high at edge m: IDLE from edge m. The next PRESENT occurs at edge m+1 at the earliest, so there is one idle cycle minimum between services.
- spurious is high for exactly the one cycle following the withdrawal edge.
- All outputs are registered, except pending_o, which is a direct view of registers.

## Structure
- **Package irq_pkg:** NUM_CH, ID_W, NO_ID constant, state enum {IDLE, PRESENT, SERVICE}.
- **Sub-module irq_prio_enc:** combinational lowest-index priority encoder. Takes the candidate vector; outputs any and id.
- **Top level:** synchroniser, pending logic, FSM and output registers.

## Test plan
- **Edge request:** reset, edge_mode=all 1, pulse irq_in[5] for 1 cycle.
  - irq_valid at k+3 with irq_id=5.
  - ack → busy=1, pending_o[5]=0.
  - eoi → irq_valid=0, irq_id=NO_ID.
- **Priority and stability:** edges on channels 3 and 7 in the same cycle → irq_id=3.
  - Channel 1 edge during PRESENT → irq_id stays 3.
  - After eoi, channel 1 is presented next, then channel 7.
- **Mask:** mask[2]=1, edge on channel 2 → pending_o[2]=1, no irq_valid. Clear the mask → irq_id=2 presented 1 cycle later.
- **Level withdrawal:** level channel 4 is held high, then dropped in PRESENT without ack → spurious pulses once, FSM returns to IDLE, no busy.
- **Simultaneous events:** in PRESENT for channel 6 (edge mode), a new edge on channel 6 arrives in the ack cycle → channel 6 re-presented 1 cycle after eoi.
- **Reset mid-service:** rst_n low during SERVICE → busy=0, irq_valid=0, irq_id=NO_ID, pending_o=0 immediately, without waiting for a clock edge.
